// File: rtl/decoder.sv
// Three-channel registered BCD to 7-segment decoder, segment order a..g on bits 6..0.
// Define DECODER_ACTIVE_LOW_SEG_EN to invert all outputs for common-anode displays.
module decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Minutos,
    input  logic [3:0] DezenaSeg,
    input  logic [3:0] UnidadeSeg,
    output logic [6:0] OutMinutos,
    output logic [6:0] OutDezenaSeg,
    output logic [6:0] OutUnidadeSeg
);

`ifdef DECODER_ACTIVE_LOW_SEG_EN
    localparam logic [6:0] POL_MASK = 7'b1111111;
`else
    localparam logic [6:0] POL_MASK = 7'b0000000;
`endif

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam int         NCH       = 3;

    // Unknown or out-of-range codes fall through to the dash pattern.
    function automatic logic [6:0] bcd2seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

    logic [3:0] bcd   [NCH];
    logic [6:0] seg_d [NCH];
    logic [6:0] seg_q [NCH];

    assign bcd[0] = Minutos;
    assign bcd[1] = DezenaSeg;
    assign bcd[2] = UnidadeSeg;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            seg_d[i] = bcd2seg(bcd[i]) ^ POL_MASK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                seg_q[i] <= SEG_BLANK ^ POL_MASK;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                seg_q[i] <= seg_d[i];
            end
        end
    end

    assign OutMinutos    = seg_q[0];
    assign OutDezenaSeg  = seg_q[1];
    assign OutUnidadeSeg = seg_q[2];

endmodule

// File: tb/tb_decoder.sv
// Directed and random checks of the three-channel BCD to 7-segment decoder.
// Expected patterns come from a digit lookup table plus a polarity mask.
module tb_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] Minutos = 4'd0;
    logic [3:0] DezenaSeg = 4'd0;
    logic [3:0] UnidadeSeg = 4'd0;
    logic [6:0] OutMinutos;
    logic [6:0] OutDezenaSeg;
    logic [6:0] OutUnidadeSeg;

    int vectors = 0;
    int miscompares = 0;

`ifdef DECODER_ACTIVE_LOW_SEG_EN
    localparam logic [6:0] MASK = 7'h7F;
`else
    localparam logic [6:0] MASK = 7'h00;
`endif

    logic [6:0] digit_tbl [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    decoder dut (
        .clk(clk),
        .rst_n(rst_n),
        .Minutos(Minutos),
        .DezenaSeg(DezenaSeg),
        .UnidadeSeg(UnidadeSeg),
        .OutMinutos(OutMinutos),
        .OutDezenaSeg(OutDezenaSeg),
        .OutUnidadeSeg(OutUnidadeSeg)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] model(input int v);
        if (v <= 9) return digit_tbl[v] ^ MASK;
        return 7'b0000001 ^ MASK;
    endfunction

    task automatic check(input string tag, input logic [6:0] obs,
                         input logic [6:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check3(input string tag, input int m, input int d,
                          input int u);
        check({tag, ".min"}, OutMinutos, model(m));
        check({tag, ".dez"}, OutDezenaSeg, model(d));
        check({tag, ".uni"}, OutUnidadeSeg, model(u));
    endtask

    task automatic check_blank(input string tag);
        check({tag, ".min"}, OutMinutos, 7'b0000000 ^ MASK);
        check({tag, ".dez"}, OutDezenaSeg, 7'b0000000 ^ MASK);
        check({tag, ".uni"}, OutUnidadeSeg, 7'b0000000 ^ MASK);
    endtask

    task automatic step(input string tag, input int m, input int d,
                        input int u);
        @(negedge clk);
        Minutos = 4'(m);
        DezenaSeg = 4'(d);
        UnidadeSeg = 4'(u);
        @(posedge clk);
        #1;
        check3(tag, m, d, u);
    endtask

    initial begin
        int m, d, u;
        // reset blanks without any clock edge
        Minutos = 4'd9;
        DezenaSeg = 4'd3;
        UnidadeSeg = 4'd12;
        #2;
        check_blank("rst_noclk");
        @(posedge clk);
        #1;
        check_blank("rst_held");
        // release between edges: no change until next edge
        @(negedge clk);
        Minutos = 4'd0;
        DezenaSeg = 4'd0;
        UnidadeSeg = 4'd0;
        #1;
        rst_n = 1'b1;
        #1;
        check_blank("rel_noedge");
        @(posedge clk);
        #1;
        check3("first", 0, 0, 0);

        for (int v = 0; v < 10; v++) step("sweep", v, v, v);
        step("invalid", 10, 15, 3);
        for (int v = 10; v < 16; v++) step("dash", v, 15 - v + 10, v);

        // distinct inputs then a mid-cycle change
        step("distinct", 7, 4, 2);
        #2;
        Minutos = 4'd1;
        DezenaSeg = 4'd5;
        UnidadeSeg = 4'd9;
        #1;
        check3("midcyc", 7, 4, 2);
        @(posedge clk);
        #1;
        check3("midcyc_next", 1, 5, 9);
        @(posedge clk);
        #1;
        check3("hold", 1, 5, 9);

        // reset pulse between edges
        step("eights", 8, 8, 8);
        #2;
        rst_n = 1'b0;
        #1;
        check_blank("pulse_low");
        #1;
        rst_n = 1'b1;
        #1;
        check_blank("pulse_rel");
        @(posedge clk);
        #1;
        check3("pulse_next", 8, 8, 8);

        for (int i = 0; i < 200; i++) begin
            m = int'($urandom_range(0, 15));
            d = int'($urandom_range(0, 15));
            u = int'($urandom_range(0, 15));
            step("rand", m, d, u);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
